// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the asynchronous FIFO pointer blocks.
//   ADDR_SIZE_DEFAULT             : default FIFO address width (depth = 2**3)
//   ALMOST_FULL_THRESHOLD_DEFAULT : default almost-full fill level
//   CONV_W                        : working width of the Gray conversion helpers
//   WRITE_LEVEL_ENABLED           : 1 when the build defines WRITE_LEVEL_EN
//   bin_to_gray / gray_to_bin     : pointer code conversions
// Pointers narrower than CONV_W are zero-extended before conversion; leading
// zeros leave both conversions unchanged in the low bits, so callers simply
// cast the result back to their own width.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int ADDR_SIZE_DEFAULT             = 3;
    localparam int ALMOST_FULL_THRESHOLD_DEFAULT = 6;
    localparam int CONV_W                        = 32;

`ifdef WRITE_LEVEL_EN
    localparam bit WRITE_LEVEL_ENABLED = 1'b1;
`else
    localparam bit WRITE_LEVEL_ENABLED = 1'b0;
`endif

    function automatic logic [CONV_W-1:0] bin_to_gray(input logic [CONV_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [CONV_W-1:0] gray_to_bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin[CONV_W-1] = gray[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_binary_block.sv
// -----------------------------------------------------------------------------
// gray_to_binary_block
// Purely combinational Gray-to-binary decoder for a FIFO pointer.
// Parameters:
//   width  : pointer width in bits
// Ports:
//   i_gray : Gray-coded pointer
//   o_bin  : binary equivalent
// -----------------------------------------------------------------------------
module gray_to_binary_block
    import async_fifo_pkg::*;
#(
    parameter int width = ADDR_SIZE_DEFAULT + 1
) (
    input  logic [width-1:0] i_gray,
    output logic [width-1:0] o_bin
);

    assign o_bin = width'(gray_to_bin(CONV_W'(i_gray)));

endmodule

// File: rtl/write_pointer_full_block.sv
// -----------------------------------------------------------------------------
// write_pointer_full_block
// Write-domain half of an asynchronous FIFO: owns the write pointer, produces
// the Gray pointer for the read-domain synchronizer and the full / almost-full
// / level / overflow status seen by the producer.
//
// Build option:
//   WRITE_LEVEL_EN : when defined, write_level_o and write_almost_full_o are
//                    computed from the synchronized read pointer; otherwise
//                    both are constant 0 and no Gray decode is built.
//
// Parameters:
//   addr_size             : address width, depth = 2**addr_size (>= 2)
//   almost_full_threshold : level at or above which almost-full asserts
//
// Ports (all state on the rising edge of write_clock_i):
//   write_clock_i           in   write-domain clock
//   write_reset_i           in   synchronous active-high reset
//   write_en_i              in   producer write request
//   read_to_write_pointer_i in   Gray read pointer, already synchronized
//   write_accept_o          out  memory write enable (comb)
//   write_address_o         out  memory write address
//   write_pointer_o         out  registered Gray write pointer
//   write_full_o            out  registered full flag
//   write_almost_full_o     out  registered almost-full flag
//   write_level_o           out  registered fill level (0..depth)
//   write_overflow_o        out  sticky write-while-full flag
// -----------------------------------------------------------------------------
module write_pointer_full_block
    import async_fifo_pkg::*;
#(
    parameter int addr_size             = ADDR_SIZE_DEFAULT,
    parameter int almost_full_threshold = ALMOST_FULL_THRESHOLD_DEFAULT
) (
    input  logic                 write_clock_i,
    input  logic                 write_reset_i,
    input  logic                 write_en_i,
    input  logic [addr_size:0]   read_to_write_pointer_i,
    output logic                 write_accept_o,
    output logic [addr_size-1:0] write_address_o,
    output logic [addr_size:0]   write_pointer_o,
    output logic                 write_full_o,
    output logic                 write_almost_full_o,
    output logic [addr_size:0]   write_level_o,
    output logic                 write_overflow_o
);

    localparam int PW = addr_size + 1;

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic          r_full;
    logic          r_almost_full;
    logic [PW-1:0] r_level;
    logic          r_overflow;

    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_full_pattern;
    logic          w_full_next;
    logic [PW-1:0] w_level_next;
    logic          w_almost_full_next;

    // A request while full is dropped here, so the pointer never overruns.
    assign write_accept_o = write_en_i & ~r_full;

    assign w_bin_next  = r_bin + PW'(write_accept_o);
    assign w_gray_next = PW'(bin_to_gray(CONV_W'(w_bin_next)));

    // The write pointer is exactly one lap (2**addr_size entries) ahead of the
    // read pointer when, in Gray code, the top two bits are inverted and the
    // rest match.
    assign w_full_pattern = {~read_to_write_pointer_i[PW-1:PW-2],
                             read_to_write_pointer_i[PW-3:0]};
    assign w_full_next    = (w_gray_next == w_full_pattern);

`ifdef WRITE_LEVEL_EN
    logic [PW-1:0] w_read_bin;

    gray_to_binary_block #(
        .width (PW)
    ) u_read_decode (
        .i_gray (read_to_write_pointer_i),
        .o_bin  (w_read_bin)
    );

    // Modular subtraction stays correct across pointer wrap.
    assign w_level_next       = w_bin_next - w_read_bin;
    assign w_almost_full_next = (w_level_next >= PW'(almost_full_threshold));
`else
    assign w_level_next       = '0;
    assign w_almost_full_next = 1'b0;
`endif

    // NOTE: non-blocking assignments make every register here sample the
    // pre-edge values, so the ordering of statements inside this block cannot
    // change behaviour.
    always_ff @(posedge write_clock_i) begin
        if (write_reset_i) begin
            r_bin         <= '0;
            r_gray        <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_level       <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_bin         <= w_bin_next;
            r_gray        <= w_gray_next;
            r_full        <= w_full_next;
            r_almost_full <= w_almost_full_next;
            r_level       <= w_level_next;
            r_overflow    <= r_overflow | (write_en_i & r_full);
        end
    end

    assign write_address_o     = r_bin[addr_size-1:0];
    assign write_pointer_o     = r_gray;
    assign write_full_o        = r_full;
    assign write_almost_full_o = r_almost_full;
    assign write_level_o       = r_level;
    assign write_overflow_o    = r_overflow;

endmodule
